rfsoc_axil_regs: RTL and testbench

//  AXI4-Lite slave register file for the RFSoC ADC capture path. It is the software view of the RFSOC_REG

---
 rtl/rfsoc_reg_pkg.sv | 33 +++
 rtl/axil_slave_if.sv | 112 +++++++++++
 rtl/rfsoc_axil_regs.sv | 146 ++++++++++++++
 tb/tb_rfsoc_axil_regs.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rfsoc_reg_pkg.sv
// Shared register map for the RFSoC ADC capture control block:
// byte offsets, CTRL bit positions and the version word.
package rfsoc_reg_pkg;

    localparam logic [7:0] REG_VERSION    = 8'h00;
    localparam logic [7:0] REG_SCRATCH    = 8'h04;
    localparam logic [7:0] REG_DM_STATUS  = 8'h08;
    localparam logic [7:0] REG_START_ADDR = 8'h0C;
    localparam logic [7:0] REG_CAP_SIZE   = 8'h10;
    localparam logic [7:0] REG_CTRL       = 8'h14;
    localparam logic [7:0] REG_CUR_ADDR   = 8'h18;
    localparam logic [7:0] REG_RUN_CYCLES = 8'h1C;

    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_RESET = 1;
    localparam int unsigned CTRL_DONE  = 8;
    localparam int unsigned CTRL_ERR   = 9;

    localparam logic [31:0] VERSION_DEFAULT = 32'h0001_0000;

    // Merge new data into an existing word, one byte lane per strobe bit.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axil_slave_if.sv
// AXI4-Lite slave handshake engine: one-entry AW/W holding registers, a single
// outstanding write response and a single registered read beat.
module axil_slave_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    axilite_clk,
    input  logic                    axilite_rstb,
    input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic                    s_axil_awvalid,
    output logic                    s_axil_awready,
    input  logic [DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axil_wstrb,
    input  logic                    s_axil_wvalid,
    output logic                    s_axil_wready,
    output logic [1:0]              s_axil_bresp,
    output logic                    s_axil_bvalid,
    input  logic                    s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic                    s_axil_arvalid,
    output logic                    s_axil_arready,
    output logic [DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]              s_axil_rresp,
    output logic                    s_axil_rvalid,
    input  logic                    s_axil_rready,
    output logic                    wr_en,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic [DATA_WIDTH/8-1:0] wr_strb,
    output logic                    rd_en,
    output logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic [DATA_WIDTH-1:0]   rd_data
);

    logic                    live_q;
    logic                    aw_held_q;
    logic [ADDR_WIDTH-1:0]   aw_addr_q;
    logic                    w_held_q;
    logic [DATA_WIDTH-1:0]   w_data_q;
    logic [DATA_WIDTH/8-1:0] w_strb_q;
    logic                    bvalid_q;
    logic                    rvalid_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    aw_fire;
    logic                    w_fire;

    // live_q keeps every ready low while reset is asserted and for the first edge after.
    assign s_axil_awready = live_q & ~aw_held_q & ~bvalid_q;
    assign s_axil_wready  = live_q & ~w_held_q & ~bvalid_q;
    assign s_axil_arready = live_q & ~rvalid_q;

    assign aw_fire = s_axil_awvalid & s_axil_awready;
    assign w_fire  = s_axil_wvalid & s_axil_wready;

    assign wr_en   = aw_held_q & w_held_q;
    assign wr_addr = aw_addr_q;
    assign wr_data = w_data_q;
    assign wr_strb = w_strb_q;
    assign rd_en   = s_axil_arvalid & s_axil_arready;
    assign rd_addr = s_axil_araddr;

    assign s_axil_bresp  = 2'b00;
    assign s_axil_bvalid = bvalid_q;
    assign s_axil_rresp  = 2'b00;
    assign s_axil_rvalid = rvalid_q;
    assign s_axil_rdata  = rdata_q;

    always_ff @(posedge axilite_clk or negedge axilite_rstb) begin
        if (!axilite_rstb) begin
            live_q    <= 1'b0;
            aw_held_q <= 1'b0;
            aw_addr_q <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            live_q <= 1'b1;

            if (aw_fire) begin
                aw_held_q <= 1'b1;
                aw_addr_q <= s_axil_awaddr;
            end else if (wr_en) begin
                aw_held_q <= 1'b0;
            end

            if (w_fire) begin
                w_held_q <= 1'b1;
                w_data_q <= s_axil_wdata;
                w_strb_q <= s_axil_wstrb;
            end else if (wr_en) begin
                w_held_q <= 1'b0;
            end

            if (wr_en) begin
                bvalid_q <= 1'b1;
            end else if (bvalid_q && s_axil_bready) begin
                bvalid_q <= 1'b0;
            end

            if (rd_en) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data;
            end else if (rvalid_q && s_axil_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rfsoc_axil_regs.sv
// AXI4-Lite register file for the RFSoC ADC capture path: capture configuration,
// start/reset strobes and data-mover status readback.
module rfsoc_axil_regs
    import rfsoc_reg_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [31:0] VERSION    = VERSION_DEFAULT
) (
    input  logic                    axilite_clk,
    input  logic                    axilite_rstb,
    input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic                    s_axil_awvalid,
    output logic                    s_axil_awready,
    input  logic [DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axil_wstrb,
    input  logic                    s_axil_wvalid,
    output logic                    s_axil_wready,
    output logic [1:0]              s_axil_bresp,
    output logic                    s_axil_bvalid,
    input  logic                    s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic                    s_axil_arvalid,
    output logic                    s_axil_arready,
    output logic [DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]              s_axil_rresp,
    output logic                    s_axil_rvalid,
    input  logic                    s_axil_rready,
    output logic                    adc_start,
    output logic                    adc_reset,
    output logic [31:0]             adc_start_addr,
    output logic [31:0]             adc_cap_size,
    input  logic [31:0]             adc_datamover_status,
    input  logic [31:0]             adc_current_addr,
    input  logic [31:0]             adc_run_cycles,
    input  logic                    adc_wr_mm2s_err,
    input  logic                    adc_cap_done
);

    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH/8-1:0] wr_strb;
    logic                    rd_en;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic [7:0]              wr_off;
    logic [7:0]              rd_off;

    logic [31:0] scratch_q;
    logic [31:0] start_addr_q;
    logic [31:0] cap_size_q;
    logic        start_q;
    logic        reset_q;

    axil_slave_if #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_axil_slave_if (
        .axilite_clk    (axilite_clk),
        .axilite_rstb   (axilite_rstb),
        .s_axil_awaddr  (s_axil_awaddr),
        .s_axil_awvalid (s_axil_awvalid),
        .s_axil_awready (s_axil_awready),
        .s_axil_wdata   (s_axil_wdata),
        .s_axil_wstrb   (s_axil_wstrb),
        .s_axil_wvalid  (s_axil_wvalid),
        .s_axil_wready  (s_axil_wready),
        .s_axil_bresp   (s_axil_bresp),
        .s_axil_bvalid  (s_axil_bvalid),
        .s_axil_bready  (s_axil_bready),
        .s_axil_araddr  (s_axil_araddr),
        .s_axil_arvalid (s_axil_arvalid),
        .s_axil_arready (s_axil_arready),
        .s_axil_rdata   (s_axil_rdata),
        .s_axil_rresp   (s_axil_rresp),
        .s_axil_rvalid  (s_axil_rvalid),
        .s_axil_rready  (s_axil_rready),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_strb        (wr_strb),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data)
    );

    // Only addr[7:2] is decoded; everything above aliases onto the same map.
    assign wr_off = {wr_addr[7:2], 2'b00};
    assign rd_off = {rd_addr[7:2], 2'b00};

    logic unused_bits;
    assign unused_bits = ^{wr_addr[ADDR_WIDTH-1:8], wr_addr[1:0],
                           rd_addr[ADDR_WIDTH-1:8], rd_addr[1:0], rd_en};

    always_ff @(posedge axilite_clk or negedge axilite_rstb) begin
        if (!axilite_rstb) begin
            scratch_q    <= '0;
            start_addr_q <= '0;
            cap_size_q   <= '0;
            start_q      <= 1'b0;
            reset_q      <= 1'b0;
        end else begin
            start_q <= 1'b0;
            reset_q <= 1'b0;
            if (wr_en) begin
                case (wr_off)
                    REG_SCRATCH:    scratch_q    <= apply_strb(scratch_q, wr_data, wr_strb);
                    REG_START_ADDR: start_addr_q <= apply_strb(start_addr_q, wr_data, wr_strb);
                    REG_CAP_SIZE:   cap_size_q   <= apply_strb(cap_size_q, wr_data, wr_strb);
                    REG_CTRL: begin
                        if (wr_strb[0]) begin
                            start_q <= wr_data[CTRL_START];
                            reset_q <= wr_data[CTRL_RESET];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_off)
            REG_VERSION:    rd_data = VERSION;
            REG_SCRATCH:    rd_data = scratch_q;
            REG_DM_STATUS:  rd_data = adc_datamover_status;
            REG_START_ADDR: rd_data = start_addr_q;
            REG_CAP_SIZE:   rd_data = cap_size_q;
            REG_CTRL: begin
                rd_data[CTRL_DONE] = adc_cap_done;
                rd_data[CTRL_ERR]  = adc_wr_mm2s_err;
            end
            REG_CUR_ADDR:   rd_data = adc_current_addr;
            REG_RUN_CYCLES: rd_data = adc_run_cycles;
            default: ;
        endcase
    end

    assign adc_start      = start_q;
    assign adc_reset      = reset_q;
    assign adc_start_addr = start_addr_q;
    assign adc_cap_size   = cap_size_q;

endmodule

// File: tb/tb_rfsoc_axil_regs.sv
// Self-checking bench for rfsoc_axil_regs: vector table, directed handshake corners
// and a randomized phase checked against a register-map model.
module tb_rfsoc_axil_regs;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        adc_start;
    logic        adc_reset;
    logic [31:0] adc_start_addr;
    logic [31:0] adc_cap_size;
    logic [31:0] dm_status = '0;
    logic [31:0] cur_addr = '0;
    logic [31:0] run_cycles = '0;
    logic        mm2s_err = 1'b0;
    logic        cap_done = 1'b0;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int reset_cnt = 0;
    int both_cnt = 0;

    logic [31:0] m_scratch = '0;
    logic [31:0] m_saddr = '0;
    logic [31:0] m_csize = '0;

    rfsoc_axil_regs dut (
        .axilite_clk          (clk),
        .axilite_rstb         (rstb),
        .s_axil_awaddr        (awaddr),
        .s_axil_awvalid       (awvalid),
        .s_axil_awready       (awready),
        .s_axil_wdata         (wdata),
        .s_axil_wstrb         (wstrb),
        .s_axil_wvalid        (wvalid),
        .s_axil_wready        (wready),
        .s_axil_bresp         (bresp),
        .s_axil_bvalid        (bvalid),
        .s_axil_bready        (bready),
        .s_axil_araddr        (araddr),
        .s_axil_arvalid       (arvalid),
        .s_axil_arready       (arready),
        .s_axil_rdata         (rdata),
        .s_axil_rresp         (rresp),
        .s_axil_rvalid        (rvalid),
        .s_axil_rready        (rready),
        .adc_start            (adc_start),
        .adc_reset            (adc_reset),
        .adc_start_addr       (adc_start_addr),
        .adc_cap_size         (adc_cap_size),
        .adc_datamover_status (dm_status),
        .adc_current_addr     (cur_addr),
        .adc_run_cycles       (run_cycles),
        .adc_wr_mm2s_err      (mm2s_err),
        .adc_cap_done         (cap_done)
    );

    always #5 clk = ~clk;

    // Strobes are counted once per cycle in which they are high.
    always @(negedge clk) begin
        if (adc_start) start_cnt++;
        if (adc_reset) reset_cnt++;
        if (adc_start && adc_reset) both_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb);
        case (addr[7:0] & 8'hFC)
            8'h04: m_scratch = merge(m_scratch, data, strb);
            8'h0C: m_saddr = merge(m_saddr, data, strb);
            8'h10: m_csize = merge(m_csize, data, strb);
            default: ;
        endcase
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        case (addr[7:0] & 8'hFC)
            8'h00: return 32'h0001_0000;
            8'h04: return m_scratch;
            8'h08: return dm_status;
            8'h0C: return m_saddr;
            8'h10: return m_csize;
            8'h14: return {22'b0, mm2s_err, cap_done, 8'b0};
            8'h18: return cur_addr;
            8'h1C: return run_cycles;
            default: return 32'h0;
        endcase
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp, output bit ok);
        bit aw_done, w_done, aw_fire, w_fire;
        int n;
        aw_done = 0; w_done = 0; n = 0;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        while (!(aw_done && w_done) && n < 50) begin
            aw_fire = awvalid && awready;
            w_fire = wvalid && wready;
            tick();
            if (aw_fire) begin awvalid = 1'b0; aw_done = 1; end
            if (w_fire) begin wvalid = 1'b0; w_done = 1; end
            n++;
        end
        while (!bvalid && n < 50) begin
            tick();
            n++;
        end
        ok = bvalid;
        resp = bresp;
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output bit ok);
        bit fired, ar_fire;
        int n;
        fired = 0; n = 0;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        while (!fired && n < 50) begin
            ar_fire = arvalid && arready;
            tick();
            if (ar_fire) begin arvalid = 1'b0; fired = 1; end
            n++;
        end
        while (!rvalid && n < 50) begin
            tick();
            n++;
        end
        ok = rvalid;
        data = rdata;
        resp = rresp;
        arvalid = 1'b0;
        tick();
        rready = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[18];

    initial begin
        logic [31:0] rd;
        logic [1:0]  resp;
        bit          ok;
        int          s0, r0, b0, n;
        logic [31:0] held;

        vecs[0]  = '{0, 32'h00, 32'h0, 4'h0, 32'h0001_0000};
        vecs[1]  = '{0, 32'h0C, 32'h0, 4'h0, 32'h0};
        vecs[2]  = '{0, 32'h10, 32'h0, 4'h0, 32'h0};
        vecs[3]  = '{0, 32'h04, 32'h0, 4'h0, 32'h0};
        vecs[4]  = '{1, 32'h0C, 32'h0, 4'hF, 32'h0};
        vecs[5]  = '{1, 32'h10, 32'd640, 4'hF, 32'h0};
        vecs[6]  = '{0, 32'h0C, 32'h0, 4'h0, 32'h0};
        vecs[7]  = '{0, 32'h10, 32'h0, 4'h0, 32'd640};
        vecs[8]  = '{1, 32'h04, 32'hA5A5_5A5A, 4'b0011, 32'h0};
        vecs[9]  = '{0, 32'h04, 32'h0, 4'h0, 32'h0000_5A5A};
        vecs[10] = '{0, 32'h08, 32'h0, 4'h0, 32'h11};
        vecs[11] = '{0, 32'h18, 32'h0, 4'h0, 32'h1234_5670};
        vecs[12] = '{0, 32'h1C, 32'h0, 4'h0, 32'h99};
        vecs[13] = '{0, 32'h40, 32'h0, 4'h0, 32'h0};
        vecs[14] = '{1, 32'h00, 32'hFFFF_FFFF, 4'hF, 32'h0};
        vecs[15] = '{0, 32'h00, 32'h0, 4'h0, 32'h0001_0000};
        vecs[16] = '{1, 32'h44, 32'hFFFF_FFFF, 4'hF, 32'h0};
        vecs[17] = '{0, 32'h44, 32'h0, 4'h0, 32'h0};

        // Reset values while reset is held
        repeat (3) tick();
        check("rst_awready", {31'b0, awready}, 32'h0);
        check("rst_wready", {31'b0, wready}, 32'h0);
        check("rst_arready", {31'b0, arready}, 32'h0);
        check("rst_bvalid", {31'b0, bvalid}, 32'h0);
        check("rst_rvalid", {31'b0, rvalid}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_strobes", {30'b0, adc_start, adc_reset}, 32'h0);
        check("rst_cap_size", adc_cap_size, 32'h0);
        rstb = 1'b1;
        tick();

        dm_status = 32'h11; cur_addr = 32'h1234_5670; run_cycles = 32'h99;

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, ok);
                model_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
                check($sformatf("vec%0d_bdone", i), {31'b0, ok}, 32'h1);
                check($sformatf("vec%0d_bresp", i), {30'b0, resp}, 32'h0);
            end else begin
                axi_read(vecs[i].addr, rd, resp, ok);
                check($sformatf("vec%0d_rdone", i), {31'b0, ok}, 32'h1);
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
                check($sformatf("vec%0d_rresp", i), {30'b0, resp}, 32'h0);
            end
        end
        check("port_start_addr", adc_start_addr, 32'h0);
        check("port_cap_size", adc_cap_size, 32'd640);

        // W1P strobes
        s0 = start_cnt; r0 = reset_cnt; b0 = both_cnt;
        axi_write(32'h14, 32'h1, 4'hF, resp, ok);
        check("start_pulse", start_cnt - s0, 1);
        check("start_no_reset", reset_cnt - r0, 0);
        axi_read(32'h14, rd, resp, ok);
        check("ctrl_bit0_reads0", rd, 32'h0);
        s0 = start_cnt; r0 = reset_cnt; b0 = both_cnt;
        axi_write(32'h14, 32'h3, 4'hF, resp, ok);
        check("both_start", start_cnt - s0, 1);
        check("both_reset", reset_cnt - r0, 1);
        check("both_together", both_cnt - b0, 1);
        s0 = start_cnt;
        axi_write(32'h14, 32'h3, 4'hE, resp, ok);
        check("w1p_needs_strb0", start_cnt - s0, 0);

        // CTRL status bits
        cap_done = 1'b0;
        axi_read(32'h14, rd, resp, ok);
        check("ctrl_done0", rd, 32'h0);
        cap_done = 1'b1; mm2s_err = 1'b1;
        axi_read(32'h14, rd, resp, ok);
        check("ctrl_done_err", rd, 32'h0000_0300);

        // AW and W in the same cycle: bvalid two cycles later, strobe with it
        s0 = start_cnt;
        awaddr = 32'h14; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        check("same_cycle_ready", {30'b0, awready, wready}, 32'h3);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("same_cycle_b_early", {31'b0, bvalid}, 32'h0);
        tick();
        check("same_cycle_b_at2", {31'b0, bvalid}, 32'h1);
        check("same_cycle_start", {31'b0, adc_start}, 32'h1);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("same_cycle_b_drop", {31'b0, bvalid}, 32'h0);
        check("same_cycle_start_1cyc", start_cnt - s0, 1);

        // W before AW, then backpressure on B and R
        wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1'b1; n = 0;
        while (!wready && n < 20) begin tick(); n++; end
        tick();
        wvalid = 1'b0;
        repeat (2) tick();
        check("w_only_no_commit", {31'b0, bvalid}, 32'h0);
        awaddr = 32'h04; awvalid = 1'b1; n = 0;
        while (!awready && n < 20) begin tick(); n++; end
        tick();
        awvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin tick(); n++; end
        check("late_aw_bvalid", {31'b0, bvalid}, 32'h1);
        model_write(32'h04, 32'h0BAD_F00D, 4'hF);
        araddr = 32'h04; arvalid = 1'b1; n = 0;
        while (!arready && n < 20) begin tick(); n++; end
        tick();
        arvalid = 1'b0;
        held = rdata;
        check("stall_rdata", held, 32'h0BAD_F00D);
        awaddr = 32'h0C; wdata = 32'hFFFF_FFFF; araddr = 32'h00;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("stall%0d_valids", c), {30'b0, bvalid, rvalid}, 32'h3);
            check($sformatf("stall%0d_rdata", c), rdata, held);
            check($sformatf("stall%0d_readies", c), {29'b0, awready, wready, arready}, 32'h0);
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        check("stall_release", {30'b0, bvalid, rvalid}, 32'h0);
        check("stall_no_second_write", adc_start_addr, m_saddr);

        // Randomized traffic against the map model
        for (int it = 0; it < 80; it++) begin
            logic [31:0] a, d;
            logic [3:0]  st;
            int          idx;
            bit          exp_p;
            dm_status = $urandom; cur_addr = $urandom; run_cycles = $urandom;
            cap_done = 1'($urandom); mm2s_err = 1'($urandom);
            idx = $urandom_range(0, 9);
            a = (idx < 8) ? 32'(idx * 4) : ((idx == 8) ? 32'h40 : 32'h3C);
            a = a | ($urandom & 32'hFFFF_FF00);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                st = 4'($urandom_range(0, 15));
                if (idx == 5 && $urandom_range(0, 1) == 1) d[0] = 1'b1;
                exp_p = (a[7:0] == 8'h14) && st[0] && d[0];
                s0 = start_cnt;
                axi_write(a, d, st, resp, ok);
                model_write(a, d, st);
                check($sformatf("rnd%0d_wr_ok", it), {30'b0, resp, ok} & 32'h7, 32'h1);
                check($sformatf("rnd%0d_start", it), start_cnt - s0, exp_p ? 1 : 0);
            end else begin
                axi_read(a, rd, resp, ok);
                check($sformatf("rnd%0d_rd_ok", it), {30'b0, resp, ok} & 32'h7, 32'h1);
                check($sformatf("rnd%0d_rdata", it), rd, model_read(a));
            end
            check($sformatf("rnd%0d_cap_size", it), adc_cap_size, m_csize);
        end

        // Reset in the middle of a write
        axi_write(32'h0C, 32'hDEAD_0000, 4'hF, resp, ok);
        check("pre_rst_saddr", adc_start_addr, 32'hDEAD_0000);
        awaddr = 32'h10; awvalid = 1'b1; n = 0;
        while (!awready && n < 20) begin tick(); n++; end
        tick();
        awvalid = 1'b0;
        rstb = 1'b0;
        #1;
        m_scratch = '0; m_saddr = '0; m_csize = '0;
        check("midrst_bvalid", {31'b0, bvalid}, 32'h0);
        check("midrst_saddr", adc_start_addr, 32'h0);
        check("midrst_awready", {31'b0, awready}, 32'h0);
        tick();
        rstb = 1'b1;
        tick();
        wdata = 32'h5; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        repeat (2) tick();
        check("midrst_aw_dropped", {31'b0, bvalid}, 32'h0);
        awaddr = 32'h04; awvalid = 1'b1; bready = 1'b1; n = 0;
        while (!awready && n < 20) begin tick(); n++; end
        tick();
        awvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin tick(); n++; end
        tick();
        bready = 1'b0;
        model_write(32'h04, 32'h5, 4'hF);
        axi_read(32'h04, rd, resp, ok);
        check("post_rst_scratch", rd, m_scratch);
        axi_read(32'h10, rd, resp, ok);
        check("post_rst_cap_size", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
